// File: rtl/pad_poll_scheduler_if.sv
// pad_poll_scheduler_if: pad connector pins, frame enable and button snapshot of the pad poll scheduler
interface pad_poll_scheduler_if #(
    parameter int NUM_PADS = 2,
    parameter int NUM_BITS = 8
);
    logic                         enable;
    logic [NUM_PADS-1:0]          data;
    logic [NUM_PADS-1:0]          latch;
    logic [NUM_PADS-1:0]          pulse;
    logic [NUM_PADS*NUM_BITS-1:0] buttons;
    logic                         frame_valid;
    logic                         busy;
    logic                         overrun;
    modport master (input enable, data, output latch, pulse, buttons, frame_valid, busy, overrun);
    modport slave (output enable, data, input latch, pulse, buttons, frame_valid, busy, overrun);
endinterface

// File: rtl/pad_poll_scheduler.sv
// pad_poll_scheduler: polls serial shift-register pads one at a time per frame tick and publishes all button bytes as one snapshot
module pad_poll_scheduler #(
    parameter int NUM_PADS     = 2,
    parameter int NUM_BITS     = 8,
    parameter int FRAME_CYCLES = 833333,
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300
) (
    input logic                  clk,
    input logic                  n_rst,
    pad_poll_scheduler_if.master bus
);
    localparam int FW  = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
    localparam int PHC = LATCH_CYCLES > HALF_CYCLES ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PHW = PHC > 1 ? $clog2(PHC) : 1;
    localparam int PW  = NUM_PADS > 1 ? $clog2(NUM_PADS) : 1;
    localparam int BW  = NUM_BITS > 1 ? $clog2(NUM_BITS) : 1;
    localparam int W   = NUM_PADS * NUM_BITS;
    localparam logic [FW-1:0]  FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_CYCLES - 1);
    localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_CYCLES - 1);
    localparam logic [PW-1:0]  PAD_LAST   = PW'(NUM_PADS - 1);
    localparam logic [BW-1:0]  BIT_LAST   = BW'(NUM_BITS - 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LATCH = 3'd1;
    localparam logic [2:0] LOW   = 3'd2;
    localparam logic [2:0] HIGH  = 3'd3;
    localparam logic [2:0] STORE = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [PHW-1:0]      phase_q, phase_d;
    logic [PW-1:0]       pad_q, pad_d;
    logic [BW-1:0]       bit_idx_q, bit_idx_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [W-1:0]        staging_q, staging_d;
    logic [W-1:0]        buttons_q, buttons_d;
    logic [NUM_PADS-1:0] latch_q, latch_d;
    logic [NUM_PADS-1:0] pulse_q, pulse_d;
    logic                frame_valid_q, frame_valid_d;
    logic                tick;

    always_comb begin
        tick          = frame_q == '0;
        frame_d       = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
        state_d       = state_q;
        phase_d       = phase_q;
        pad_d         = pad_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        staging_d     = staging_q;
        buttons_d     = buttons_q;
        frame_valid_d = 1'b0;
        case (state_q)
            IDLE: if (tick && bus.enable) begin
                state_d = LATCH;
                pad_d   = '0;
                phase_d = '0;
            end
            LATCH: if (phase_q == LATCH_LAST) begin
                state_d   = LOW;
                bit_idx_d = '0;
                phase_d   = '0;
            end else phase_d = phase_q + 1'b1;
            LOW: if (phase_q == HALF_LAST) begin
                state_d = HIGH;
                phase_d = '0;
                shift_d = (shift_q << 1) | NUM_BITS'(bus.data[pad_q]);
            end else phase_d = phase_q + 1'b1;
            HIGH: if (phase_q == HALF_LAST) begin
                phase_d   = '0;
                state_d   = (bit_idx_q == BIT_LAST) ? STORE : LOW;
                bit_idx_d = (bit_idx_q == BIT_LAST) ? bit_idx_q : bit_idx_q + 1'b1;
            end else phase_d = phase_q + 1'b1;
            STORE: begin
                staging_d[pad_q*NUM_BITS +: NUM_BITS] = shift_q;
                // the last pad's byte goes straight into the snapshot so every slice switches together
                if (pad_q == PAD_LAST) begin
                    state_d       = IDLE;
                    buttons_d     = staging_d;
                    frame_valid_d = 1'b1;
                end else begin
                    state_d = LATCH;
                    pad_d   = pad_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        latch_d = (state_d == LATCH) ? NUM_PADS'(1) << pad_d : '0;
        pulse_d = (state_d == HIGH) ? NUM_PADS'(1) << pad_d : '0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            phase_q       <= '0;
            pad_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            staging_q     <= '1;
            buttons_q     <= '1;
            latch_q       <= '0;
            pulse_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            phase_q       <= phase_d;
            pad_q         <= pad_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            staging_q     <= staging_d;
            buttons_q     <= buttons_d;
            latch_q       <= latch_d;
            pulse_q       <= pulse_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bus.latch       = latch_q;
    assign bus.pulse       = pulse_q;
    assign bus.buttons     = buttons_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.overrun     = tick && (state_q != IDLE);
endmodule

// File: tb/tb_pad_poll_scheduler.sv
// tb_pad_poll_scheduler: random pad data and enable against a timing/snapshot reference model with a frame scoreboard
module tb_pad_poll_scheduler;
    localparam int NP  = 2;
    localparam int NB  = 8;
    localparam int L   = 6;
    localparam int H   = 3;
    localparam int F   = 37;
    localparam int PAD = L + 2 * H * NB + 1;
    localparam int FL  = NP * PAD;
    localparam int W   = NP * NB;

    typedef struct {
        int           cyc;
        logic [W-1:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    pad_poll_scheduler_if #(.NUM_PADS(NP), .NUM_BITS(NB)) bus ();

    pad_poll_scheduler #(
        .NUM_PADS(NP), .NUM_BITS(NB), .FRAME_CYCLES(F), .LATCH_CYCLES(L), .HALF_CYCLES(H)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    int           cyc = 0;
    int           fstart = -1000000;
    int           errors = 0;
    int           checks = 0;
    bit           done = 1'b0;
    bit           final_ph = 1'b0;
    exp_t         sb[$];
    exp_t         got;
    logic [NB-1:0] bytes[NP];
    logic [W-1:0] published = '1;

    function automatic bit busy_at(int c);
        return c >= fstart + 1 && c <= fstart + FL;
    endfunction

    // expected latch (want_pulse=0) or pulse (want_pulse=1) pins from the frame start and cycle offsets
    function automatic logic [NP-1:0] pins(int c, bit want_pulse);
        int r = c - fstart - 1;
        int p, q;
        logic [NP-1:0] v = '0;
        if (r >= 0 && r < FL) begin
            p = r / PAD;
            q = r % PAD;
            if (!want_pulse && q < L) v[p] = 1'b1;
            if (want_pulse && q >= L && q < L + 2 * H * NB && (q - L) % (2 * H) >= H) v[p] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        int r, p, q, k;
        logic [NP-1:0] d;
        exp_t e;
        if (final_ph) bus.enable = 1'b0;
        else if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
        if (cyc % F == 0 && !busy_at(cyc) && bus.enable) begin
            fstart = cyc;
            for (int i = 0; i < NP; i++) begin
                bytes[i] = NB'($urandom);
                e.b[i*NB +: NB] = bytes[i];
            end
            e.cyc = cyc + FL + 1;
            sb.push_back(e);
        end
        d = NP'($urandom);
        r = cyc - fstart - 1;
        if (r >= 0 && r < FL) begin
            p = r / PAD;
            q = r % PAD;
            if (q >= L && q < L + 2 * H * NB && (q - L) % (2 * H) == H - 1) begin
                k = (q - L) / (2 * H);
                d[p] = bytes[p][NB-1-k];
            end
        end
        bus.data = d;
    endtask

    always @(negedge clk) begin
        if (!done) begin
            if (!n_rst) begin
                sb.delete();
                published = '1;
                check("rst_latch", 32'(bus.latch), 32'(0));
                check("rst_pulse", 32'(bus.pulse), 32'(0));
                check("rst_buttons", 32'(bus.buttons), 32'({W{1'b1}}));
                check("rst_flags", 32'({bus.frame_valid, bus.busy, bus.overrun}), 32'(0));
            end else begin
                check("latch", 32'(bus.latch), 32'(pins(cyc, 1'b0)));
                check("pulse", 32'(bus.pulse), 32'(pins(cyc, 1'b1)));
                check("busy", 32'(bus.busy), 32'(busy_at(cyc)));
                check("overrun", 32'(bus.overrun), 32'((cyc % F == 0) && busy_at(cyc)));
                if (bus.frame_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_valid_unexpected cyc=%0d got=1 want=0", cyc);
                    end else begin
                        got = sb.pop_front();
                        check("frame_valid_cycle", 32'(cyc), 32'(got.cyc));
                        check("buttons_snapshot", 32'(bus.buttons), 32'(got.b));
                        published = got.b;
                    end
                end else begin
                    check("buttons_stable", 32'(bus.buttons), 32'(published));
                    if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_valid_missing cyc=%0d got=0 want=1", cyc);
                        sb.delete(0);
                    end
                end
            end
        end
    end

    initial begin
        int  rst_cnt = 0;
        bit  rst_done = 1'b0;
        n_rst = 1'b0;
        bus.enable = 1'b1;
        bus.data = '0;
        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b1;
        cyc = 0;
        step();
        for (int g = 1; g < 3000; g++) begin
            @(posedge clk);
            #2;
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) begin
                    n_rst = 1'b1;
                    cyc = 0;
                    step();
                end
            end else if (!rst_done && g >= 1200 && busy_at(cyc + 1)) begin
                n_rst = 1'b0;
                rst_done = 1'b1;
                rst_cnt = 3;
                fstart = -1000000;
            end else begin
                cyc++;
                step();
            end
        end
        final_ph = 1'b1;
        repeat (FL + F + 5) begin
            @(posedge clk);
            #2;
            cyc++;
            step();
        end
        @(negedge clk);
        #1;
        done = 1'b1;
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
